// File: rtl/neighbor_link_fifo_pkg.sv
// Shared decoder-stage codes and boundary modes for the neighbour link family.
package neighbor_link_fifo_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;

    typedef enum logic [1:0] {
        BOUNDARY_INTERNAL = 2'd0,
        BOUNDARY_EDGE     = 2'd1,
        BOUNDARY_NONE     = 2'd2,
        BOUNDARY_FIFO     = 2'd3
    } boundary_e;

    function automatic logic is_loading_stage(input logic [STAGE_WIDTH-1:0] stage);
        return (stage == STAGE_PARAMETERS_LOADING) || (stage == STAGE_MEASUREMENT_LOADING);
    endfunction

endpackage

// File: rtl/neighbor_link_fifo_tx_fifo.sv
// Small circular message buffer; a push into a full buffer is dropped unless a pop frees a slot the same cycle.
module link_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] buf_mem [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;
    assign head_data = buf_mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            buf_mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/neighbor_link_fifo.sv
// One decoding-graph edge: growth/error/data exchange between A and B, with B optionally remote over a valid/ready channel.
module neighbor_link_fifo
    import neighbor_link_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int MAX_WEIGHT    = 7,
    parameter int TX_DEPTH      = 4,
    localparam int EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 7,
    localparam int LINK_BIT_WIDTH    = $clog2(MAX_WEIGHT + 1),
    localparam int MSG_WIDTH         = EXPOSED_DATA_SIZE + 2
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [STAGE_WIDTH-1:0]       global_stage,
    input  logic                         a_increase,
    input  logic                         b_increase,
    input  logic                         a_is_error_in,
    input  logic                         b_is_error_in,
    input  logic [EXPOSED_DATA_SIZE-1:0] a_input_data,
    input  logic [EXPOSED_DATA_SIZE-1:0] b_input_data,
    output logic [EXPOSED_DATA_SIZE-1:0] a_output_data,
    output logic [EXPOSED_DATA_SIZE-1:0] b_output_data,
    input  logic [LINK_BIT_WIDTH-1:0]    weight_in,
    input  logic [1:0]                   boundary_condition_in,
    input  logic                         erasure_in,
    output logic [LINK_BIT_WIDTH-1:0]    weight_out,
    output logic [1:0]                   boundary_condition_out,
    output logic                         fully_grown,
    output logic                         is_boundary,
    output logic                         is_error,
    output logic [MSG_WIDTH-1:0]         tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    input  logic [MSG_WIDTH-1:0]         rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic                         tx_busy,
    output logic                         overflow_err
);
    localparam int GROWTH_WIDTH = $clog2(MAX_WEIGHT + 3);

    logic [GROWTH_WIDTH-1:0]      growth_q, growth_d, growth_sum, eff_weight;
    logic [LINK_BIT_WIDTH-1:0]    weight_q, weight_d;
    boundary_e                    mode_q, mode_d;
    logic                         erasure_q, erasure_d;
    logic                         is_error_q, is_error_d, err_new;
    logic                         remote_error_q, remote_error_d;
    logic [EXPOSED_DATA_SIZE-1:0] remote_data_q, remote_data_d;
    logic                         last_error_q, last_error_d;
    logic [EXPOSED_DATA_SIZE-1:0] last_data_q, last_data_d;
    logic                         overflow_q, overflow_d;
    logic                         loading, rx_accept, r_inc, tx_push, tx_pop, tx_drop, tx_empty;

    assign loading    = is_loading_stage(global_stage);
    assign eff_weight = erasure_q ? '0 : GROWTH_WIDTH'(weight_q);
    assign rx_ready   = (mode_q == BOUNDARY_FIFO) && !loading;
    assign rx_accept  = rx_valid && rx_ready;
    assign r_inc      = rx_accept && rx_data[MSG_WIDTH-1];
    assign tx_push    = (mode_q == BOUNDARY_FIFO) && !loading &&
                        (a_increase || (a_is_error_in != last_error_q) || (a_input_data != last_data_q));
    assign tx_pop     = tx_valid && tx_ready && !loading;

    always_comb begin
        remote_error_d = rx_accept ? rx_data[MSG_WIDTH-2] : remote_error_q;
        remote_data_d  = rx_accept ? rx_data[EXPOSED_DATA_SIZE-1:0] : remote_data_q;
        growth_sum     = '0;
        err_new        = 1'b0;
        case (mode_q)
            BOUNDARY_INTERNAL: begin
                growth_sum = growth_q + GROWTH_WIDTH'(a_increase) + GROWTH_WIDTH'(b_increase);
                err_new    = a_is_error_in || b_is_error_in;
            end
            BOUNDARY_EDGE: begin
                growth_sum = growth_q + GROWTH_WIDTH'(a_increase);
                err_new    = a_is_error_in;
            end
            BOUNDARY_FIFO: begin
                growth_sum = growth_q + GROWTH_WIDTH'(a_increase) + GROWTH_WIDTH'(r_inc);
                err_new    = a_is_error_in || remote_error_d;
            end
            default: begin
                growth_sum = '0;
                err_new    = 1'b0;
            end
        endcase
    end

    always_comb begin
        growth_d     = growth_q;
        weight_d     = weight_q;
        mode_d       = mode_q;
        erasure_d    = erasure_q;
        is_error_d   = is_error_q;
        last_error_d = last_error_q;
        last_data_d  = last_data_q;
        overflow_d   = overflow_q;
        if (global_stage == STAGE_PARAMETERS_LOADING) begin
            weight_d = weight_in;
            mode_d   = boundary_e'(boundary_condition_in);
        end else if (global_stage == STAGE_MEASUREMENT_LOADING) begin
            growth_d     = '0;
            erasure_d    = erasure_in;
            is_error_d   = 1'b0;
            last_error_d = 1'b0;
            last_data_d  = '0;
            overflow_d   = 1'b0;
        end else begin
            growth_d   = (growth_sum >= eff_weight) ? eff_weight : growth_sum;
            is_error_d = err_new;
            overflow_d = overflow_q || tx_drop;
            // A dropped message still counts as sent; overflow_err already flags the loss.
            if (tx_push) begin
                last_error_d = a_is_error_in;
                last_data_d  = a_input_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            growth_q       <= '0;
            weight_q       <= '0;
            mode_q         <= BOUNDARY_INTERNAL;
            erasure_q      <= 1'b0;
            is_error_q     <= 1'b0;
            remote_error_q <= 1'b0;
            remote_data_q  <= '0;
            last_error_q   <= 1'b0;
            last_data_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            growth_q       <= growth_d;
            weight_q       <= weight_d;
            mode_q         <= mode_d;
            erasure_q      <= erasure_d;
            is_error_q     <= is_error_d;
            remote_error_q <= (global_stage == STAGE_MEASUREMENT_LOADING) ? 1'b0 : remote_error_d;
            remote_data_q  <= (global_stage == STAGE_MEASUREMENT_LOADING) ? '0 : remote_data_d;
            last_error_q   <= last_error_d;
            last_data_q    <= last_data_d;
            overflow_q     <= overflow_d;
        end
    end

    link_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (MSG_WIDTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (global_stage == STAGE_MEASUREMENT_LOADING),
        .push      (tx_push),
        .pop       (tx_pop),
        .push_data ({a_increase, a_is_error_in, a_input_data}),
        .head_data (tx_data),
        .empty     (tx_empty),
        .drop      (tx_drop)
    );

    assign tx_valid               = !tx_empty;
    assign tx_busy                = !tx_empty;
    assign overflow_err           = overflow_q;
    assign weight_out             = weight_q;
    assign boundary_condition_out = mode_q;
    assign fully_grown            = (growth_q >= eff_weight);
    assign is_boundary            = (mode_q != BOUNDARY_INTERNAL) && fully_grown;
    assign is_error               = is_error_q;
    assign a_output_data          = (mode_q == BOUNDARY_INTERNAL) ? b_input_data :
                                    (mode_q == BOUNDARY_FIFO)     ? remote_data_q : '0;
    assign b_output_data          = (mode_q == BOUNDARY_INTERNAL) ? a_input_data : '0;

endmodule
